// File: rtl/udp_payload_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_payload_streamer: streams seed + k*generator payload bytes as nibbles |
// | (low nibble first) into a FIFO write port. Optional: STATS_EN counters.  |
// | Optional macro: UDP_PAYLOAD_STREAMER_STATS_EN  Revision: 1.0             |
// +--------------------------------------------------------------------------+
module udp_payload_streamer #(
  parameter int DATA_BYTES = 256,
  parameter int WORD_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [7:0]           seed_i,
  input  logic [7:0]           generator_i,
  input  logic                 wr_rst_busy_i,
  input  logic                 wr_full_i,
  output logic                 wr_en_o,
  output logic [WORD_BITS-1:0] wr_data_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
  ,
  output logic [15:0]          pkt_count_o,
  output logic [15:0]          stall_count_o
`endif
);

  localparam int               NIB_W    = $clog2(2 * DATA_BYTES);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(2 * DATA_BYTES - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_FIFO = 2'd1;
  localparam logic [1:0] S_STREAM    = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       gen_q, gen_d;
  logic             half_q, half_d;
  logic [NIB_W-1:0] nib_cnt_q, nib_cnt_d;
  logic             wr_fire;

  assign wr_fire = (state_q == S_STREAM) && !wr_full_i && !wr_rst_busy_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_i) state_d = S_WAIT_FIFO;
      S_WAIT_FIFO: if (!wr_rst_busy_i) state_d = S_STREAM;
      S_STREAM:    if (wr_fire && (nib_cnt_q == '0)) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_o   = wr_fire;
    wr_data_o = half_q ? acc_q[7:4] : acc_q[3:0];
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
  end

  // Accumulator advances only after the high nibble has been accepted.
  always_comb begin
    acc_d     = acc_q;
    gen_d     = gen_q;
    half_d    = half_q;
    nib_cnt_d = nib_cnt_q;
    if ((state_q == S_IDLE) && start_i) begin
      acc_d     = seed_i;
      gen_d     = generator_i;
      half_d    = 1'b0;
      nib_cnt_d = LAST_NIB;
    end else if (wr_fire) begin
      half_d = ~half_q;
      if (half_q) begin
        acc_d = acc_q + gen_q;
      end
      if (nib_cnt_q != '0) begin
        nib_cnt_d = nib_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      gen_q     <= '0;
      half_q    <= 1'b0;
      nib_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      gen_q     <= gen_d;
      half_q    <= half_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    pkt_count_d   = pkt_count_q;
    stall_count_d = stall_count_q;
    if (state_q == S_DONE) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
    if ((state_q == S_STREAM) && wr_full_i && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count_o   = pkt_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_payload_streamer.sv
`default_nettype none
// Self-checking bench for udp_payload_streamer: queue-based payload model plus
// literal sequence checks from the test plan, followed by randomized traffic.
module tb_udp_payload_streamer;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] gen = 8'h00;
  logic       rbusy = 1'b0;
  logic       full = 1'b0;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       busy;
  logic       done;
`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udp_payload_streamer #(.DATA_BYTES(NB), .WORD_BITS(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start),
    .seed_i       (seed),
    .generator_i  (gen),
    .wr_rst_busy_i(rbusy),
    .wr_full_i    (full),
    .wr_en_o      (wr_en),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .done_o       (done)
`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
    ,
    .pkt_count_o  (pkt_count),
    .stall_count_o(stall_count)
`endif
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 waiting for FIFO reset, 2 streaming, 3 done.
  int          phase = 0;
  logic [3:0]  expq[$];
  logic [15:0] m_pkts = 16'd0;
  logic [15:0] m_stalls = 16'd0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase = 0;
      expq.delete();
      m_pkts = 16'd0;
      m_stalls = 16'd0;
    end else begin
      case (phase)
        0: if (start) begin
          logic [7:0] b;
          expq.delete();
          for (int k = 0; k < NB; k++) begin
            b = 8'(int'(seed) + k * int'(gen));
            expq.push_back(b[3:0]);
            expq.push_back(b[7:4]);
          end
          phase = 1;
        end
        1: if (!rbusy) phase = 2;
        2: begin
          if (full && (m_stalls != 16'hFFFF)) m_stalls = m_stalls + 16'd1;
          if (!full && !rbusy) begin
            void'(expq.pop_front());
            if (expq.size() == 0) phase = 3;
          end
        end
        default: begin
          phase = 0;
          m_pkts = m_pkts + 16'd1;
        end
      endcase
    end
  end

  // Per-cycle comparison and write log.
  logic [3:0] got[$];
  int nc = 0;
  int start_nc = -1;
  int first_nc = -1;
  int last_nc = -1;
  int done_nc = -1;

  always @(negedge clk) begin
    logic exp_wr;
    nc++;
    exp_wr = (phase == 2) && !full && !rbusy;
    chk("wr_en", int'(wr_en), int'(exp_wr));
    chk("busy", int'(busy), int'(phase != 0));
    chk("done", int'(done), int'(phase == 3));
    if (exp_wr && (expq.size() > 0)) chk("wr_data", int'(wr_data), int'(expq[0]));
`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
    chk("pkt_count", int'(pkt_count), int'(m_pkts));
    chk("stall_count", int'(stall_count), int'(m_stalls));
`endif
    if (wr_en) begin
      got.push_back(wr_data);
      if (first_nc < 0) first_nc = nc;
      last_nc = nc;
    end
    if (done) done_nc = nc;
    if (start && (phase == 0)) start_nc = nc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete();
    first_nc = -1;
    last_nc = -1;
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] g);
    start = 1'b1;
    seed = s;
    gen = g;
    tick();
    start = 1'b0;
    seed = 8'($urandom);
    gen = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && (n < 500)) begin
      tick();
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(busy), 0);
  endtask

  task automatic wait_writes(input string nm, input int cnt);
    int n = 0;
    while ((got.size() < cnt) && (n < 200)) begin
      tick();
      n++;
    end
    chk({nm, "_write_timeout"}, int'(got.size() >= cnt), 1);
  endtask

  task automatic chk_seq(input string nm, input logic [3:0] e[8]);
    chk({nm, "_count"}, got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk($sformatf("%s_nib%0d", nm, i), int'(got[i]), int'(e[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    repeat (3) tick();
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
    chk("rst_pkt_count", int'(pkt_count), 0);
    chk("rst_stall_count", int'(stall_count), 0);
`endif
    rstn = 1'b1;
    tick();

    // Basic packet, latency and done timing.
    clear_log();
    pulse_start(8'h10, 8'h03);
    wait_idle("basic");
    chk_seq("basic", '{4'h0, 4'h1, 4'h3, 4'h1, 4'h6, 4'h1, 4'h9, 4'h1});
    chk("basic_latency", first_nc - start_nc, 2);
    chk("basic_done_after_last", done_nc - last_nc, 1);
    chk("basic_contiguous", last_nc - first_nc, 7);

    // Byte wraparound.
    clear_log();
    pulse_start(8'hFE, 8'h01);
    wait_idle("wrap");
    chk_seq("wrap", '{4'hE, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0});

    // Backpressure after the third nibble.
    clear_log();
    pulse_start(8'h10, 8'h03);
    wait_writes("stall", 3);
    full = 1'b1;
    repeat (5) tick();
    full = 1'b0;
    wait_idle("stall");
    chk_seq("stall", '{4'h0, 4'h1, 4'h3, 4'h1, 4'h6, 4'h1, 4'h9, 4'h1});
    chk("stall_span", last_nc - first_nc, 12);

    // FIFO reset busy at start, plus an ignored second start.
    clear_log();
    rbusy = 1'b1;
    pulse_start(8'h20, 8'h05);
    repeat (19) tick();
    rbusy = 1'b0;
    wait_writes("rbusy", 2);
    pulse_start(8'h77, 8'h09);
    wait_idle("rbusy");
    chk_seq("rbusy", '{4'h0, 4'h2, 4'h5, 4'h2, 4'hA, 4'h2, 4'hF, 4'h2});
    chk("rbusy_latency", first_nc - start_nc, 21);

    // Asynchronous reset mid-packet.
    clear_log();
    pulse_start(8'h10, 8'h03);
    wait_writes("arst", 3);
    dn = done_nc;
    rstn = 1'b0;
    #1;
    chk("arst_wr_en", int'(wr_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("arst_no_done", done_nc, dn);
    clear_log();
    pulse_start(8'h33, 8'h11);
    wait_idle("arst_new");
    chk_seq("arst_new", '{4'h3, 4'h3, 4'h4, 4'h4, 4'h5, 4'h5, 4'h6, 4'h6});

    // Three back-to-back packets, one with a 5-cycle stall, from a fresh reset.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    pulse_start(8'h01, 8'h02);
    wait_idle("b2b0");
    clear_log();
    pulse_start(8'h10, 8'h03);
    wait_writes("b2b1", 3);
    full = 1'b1;
    repeat (5) tick();
    full = 1'b0;
    wait_idle("b2b1");
    pulse_start(8'h40, 8'h80);
    wait_idle("b2b2");
    chk("model_pkts", int'(m_pkts), 3);
    chk("model_stalls", int'(m_stalls), 5);
`ifdef UDP_PAYLOAD_STREAMER_STATS_EN
    chk("b2b_pkt_count", int'(pkt_count), 3);
    chk("b2b_stall_count", int'(stall_count), 5);
`endif

    // Randomized traffic: random starts (also while busy), backpressure, FIFO reset.
    for (int i = 0; i < 3000; i++) begin
      full  = ($urandom_range(0, 3) == 0);
      rbusy = ($urandom_range(0, 40) == 0);
      start = ($urandom_range(0, 15) == 0);
      seed  = 8'($urandom);
      gen   = 8'($urandom);
      tick();
    end
    start = 1'b0;
    full = 1'b0;
    rbusy = 1'b0;
    wait_idle("random");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
